// File: rtl/reset_sequencer.sv
// Startup/reset sequencer: holds the core in reset, waits a settle window, then runs with an uptime counter.
// Optional LED heartbeat in RUN when RESETSEQ_HEARTBEAT_EN is defined; otherwise heartbeat is tied low.
module reset_sequencer #(
  parameter int HOLD_CYCLES      = 16,
  parameter int SETTLE_CYCLES    = 8,
  parameter int HEARTBEAT_CYCLES = 1000000,
  parameter int UPTIME_WIDTH     = 32
) (
  input  logic                    divclock,
  input  logic                    reset_n,
  input  logic                    soft_reset,
  output logic                    core_reset_n,
  output logic                    ready,
  output logic [1:0]              state,
  output logic [UPTIME_WIDTH-1:0] uptime,
  output logic                    heartbeat
);

  localparam int CNT_MAX = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [1:0] ST_HOLD   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;

  localparam logic [CNT_W-1:0]        HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]        SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [UPTIME_WIDTH-1:0] UPTIME_MAX  = '1;

  logic [1:0]              state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic                    core_reset_n_reg, core_reset_n_next;
  logic                    ready_reg, ready_next;
  logic [UPTIME_WIDTH-1:0] uptime_reg, uptime_next;

  // Soft reset is checked first so it beats a terminal count on the same edge.
  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg;
    core_reset_n_next = core_reset_n_reg;
    ready_next        = ready_reg;
    uptime_next       = uptime_reg;
    if (soft_reset) begin
      state_next        = ST_HOLD;
      cnt_next          = '0;
      core_reset_n_next = 1'b0;
      ready_next        = 1'b0;
      uptime_next       = '0;
    end else begin
      case (state_reg)
        ST_HOLD: begin
          core_reset_n_next = 1'b0;
          ready_next        = 1'b0;
          if (cnt_reg == HOLD_LAST) begin
            state_next        = ST_SETTLE;
            cnt_next          = '0;
            core_reset_n_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        ST_SETTLE: begin
          core_reset_n_next = 1'b1;
          ready_next        = 1'b0;
          if (cnt_reg == SETTLE_LAST) begin
            state_next = ST_RUN;
            cnt_next   = '0;
            ready_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        ST_RUN: begin
          core_reset_n_next = 1'b1;
          ready_next        = 1'b1;
          if (uptime_reg != UPTIME_MAX) begin
            uptime_next = uptime_reg + 1'b1;
          end
        end
        default: begin
          // Unreachable encoding: fall back to a fresh hold sequence.
          state_next        = ST_HOLD;
          cnt_next          = '0;
          core_reset_n_next = 1'b0;
          ready_next        = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge divclock) begin
    if (!reset_n) begin
      state_reg        <= ST_HOLD;
      cnt_reg          <= '0;
      core_reset_n_reg <= 1'b0;
      ready_reg        <= 1'b0;
      uptime_reg       <= '0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      core_reset_n_reg <= core_reset_n_next;
      ready_reg        <= ready_next;
      uptime_reg       <= uptime_next;
    end
  end

  assign state        = state_reg;
  assign core_reset_n = core_reset_n_reg;
  assign ready        = ready_reg;
  assign uptime       = uptime_reg;

`ifdef RESETSEQ_HEARTBEAT_EN
  localparam int HB_W = $clog2(HEARTBEAT_CYCLES) + 1;
  localparam logic [HB_W-1:0] HB_LAST = HB_W'(HEARTBEAT_CYCLES - 1);

  logic [HB_W-1:0] hb_cnt_reg, hb_cnt_next;
  logic            heartbeat_reg, heartbeat_next;

  always_comb begin
    hb_cnt_next    = hb_cnt_reg;
    heartbeat_next = heartbeat_reg;
    if (soft_reset) begin
      hb_cnt_next    = '0;
      heartbeat_next = 1'b0;
    end else if (state_reg == ST_RUN) begin
      if (hb_cnt_reg == HB_LAST) begin
        hb_cnt_next    = '0;
        heartbeat_next = ~heartbeat_reg;
      end else begin
        hb_cnt_next = hb_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge divclock) begin
    if (!reset_n) begin
      hb_cnt_reg    <= '0;
      heartbeat_reg <= 1'b0;
    end else begin
      hb_cnt_reg    <= hb_cnt_next;
      heartbeat_reg <= heartbeat_next;
    end
  end

  assign heartbeat = heartbeat_reg;
`else
  logic unused_hb_cfg;
  assign unused_hb_cfg = ^HEARTBEAT_CYCLES;
  assign heartbeat     = 1'b0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer (HOLD=4, SETTLE=2, HEARTBEAT=3, UPTIME_WIDTH=4).
// Each row gives inputs for one edge and the outputs expected right after that edge.
module tb_reset_sequencer;

`ifdef RESETSEQ_HEARTBEAT_EN
  localparam bit HB_EN = 1'b1;
`else
  localparam bit HB_EN = 1'b0;
`endif

  logic       divclock = 1'b0;
  logic       reset_n = 1'b0;
  logic       soft_reset = 1'b0;
  logic       core_reset_n;
  logic       ready;
  logic [1:0] state;
  logic [3:0] uptime;
  logic       heartbeat;

  reset_sequencer #(
    .HOLD_CYCLES     (4),
    .SETTLE_CYCLES   (2),
    .HEARTBEAT_CYCLES(3),
    .UPTIME_WIDTH    (4)
  ) dut (
    .divclock    (divclock),
    .reset_n     (reset_n),
    .soft_reset  (soft_reset),
    .core_reset_n(core_reset_n),
    .ready       (ready),
    .state       (state),
    .uptime      (uptime),
    .heartbeat   (heartbeat)
  );

  always #5 divclock = ~divclock;

  typedef struct {
    string      name;
    logic [1:0] st;
    logic       crn;
    logic       rdy;
    logic [3:0] up;
    logic       hb;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Drive one edge's inputs and queue the outputs expected after that edge.
  task automatic step(input string name, input logic r, input logic s, input logic [1:0] st,
                      input logic crn, input logic rdy, input logic [3:0] up, input logic hb);
    exp_t e;
    reset_n    = r;
    soft_reset = s;
    @(posedge divclock);
    #1;
    e.name = name;
    e.st   = st;
    e.crn  = crn;
    e.rdy  = rdy;
    e.up   = up;
    e.hb   = HB_EN ? hb : 1'b0;
    exp_q.push_back(e);
  endtask

  // Monitor: compare on the falling edge, half a cycle after the update.
  always @(negedge divclock) begin
    exp_t m;
    if (exp_q.size() > 0) begin
      m = exp_q.pop_front();
      checks++;
      if (state !== m.st || core_reset_n !== m.crn || ready !== m.rdy ||
          uptime !== m.up || heartbeat !== m.hb) begin
        failures++;
        $display("FAIL %s: got st=%0d crn=%b rdy=%b up=%0d hb=%b, expected st=%0d crn=%b rdy=%b up=%0d hb=%b",
                 m.name, state, core_reset_n, ready, uptime, heartbeat,
                 m.st, m.crn, m.rdy, m.up, m.hb);
      end else begin
        $display("chk %0d %s: st=%0d crn=%b rdy=%b up=%0d hb=%b ok",
                 checks, m.name, state, core_reset_n, ready, uptime, heartbeat);
      end
    end
  end

  initial begin
    // 1. reset, then the full hold/settle/run sequence
    repeat (3) step("t1_reset", 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step("t1_hold",  1, 0, 0, 0, 0, 0, 0);
    step("t1_settle_a", 1, 0, 1, 1, 0, 0, 0);
    step("t1_settle_b", 1, 0, 1, 1, 0, 0, 0);
    step("t1_run",      1, 0, 2, 1, 1, 0, 0);

    // 2. 21 RUN cycles: uptime saturates at 15, heartbeat toggles every 3rd cycle
    for (int k = 1; k <= 21; k++) begin
      int up_i;
      up_i = (k > 15) ? 15 : k;
      step("t2_run", 1, 0, 2, 1, 1, up_i[3:0], ((k / 3) % 2) == 1);
    end

    // 3. one-cycle soft reset in RUN (heartbeat was 1), then full re-run
    step("t3_soft", 1, 1, 0, 0, 0, 0, 0);
    repeat (3) step("t3_hold", 1, 0, 0, 0, 0, 0, 0);
    step("t3_settle_a", 1, 0, 1, 1, 0, 0, 0);
    step("t3_settle_b", 1, 0, 1, 1, 0, 0, 0);
    step("t3_run0",     1, 0, 2, 1, 1, 0, 0);
    step("t3_run1",     1, 0, 2, 1, 1, 1, 0);

    // 4. soft reset landing on the HOLD->SETTLE terminal edge, then held high
    step("t4_soft", 1, 1, 0, 0, 0, 0, 0);
    repeat (3) step("t4_hold", 1, 0, 0, 0, 0, 0, 0);
    step("t4_term_soft", 1, 1, 0, 0, 0, 0, 0);
    repeat (2) step("t4_held", 1, 1, 0, 0, 0, 0, 0);
    repeat (3) step("t4_rehold", 1, 0, 0, 0, 0, 0, 0);
    step("t4_settle", 1, 0, 1, 1, 0, 0, 0);

    // 5. reset_n (with soft_reset also high) during SETTLE, restart, then reset_n in RUN
    step("t5_rst_settle", 0, 1, 0, 0, 0, 0, 0);
    repeat (3) step("t5_hold", 1, 0, 0, 0, 0, 0, 0);
    step("t5_settle_a", 1, 0, 1, 1, 0, 0, 0);
    step("t5_settle_b", 1, 0, 1, 1, 0, 0, 0);
    step("t5_run0",     1, 0, 2, 1, 1, 0, 0);
    step("t5_run1",     1, 0, 2, 1, 1, 1, 0);
    step("t5_run2",     1, 0, 2, 1, 1, 2, 0);
    step("t5_run3",     1, 0, 2, 1, 1, 3, 1);
    step("t5_rst_run",  0, 0, 0, 0, 0, 0, 0);
    step("t5_hold",     1, 0, 0, 0, 0, 0, 0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int w = 0; w < 8 && exp_q.size() > 0; w++) @(negedge divclock);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
